// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM states shared by the multi-cycle ALU.
package alu_pkg;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/alu_mc_comb.sv
// alu_mc_comb: single-cycle result and ADD/SUB flags for every opcode except SLL.
module alu_mc_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             of_o,
  output logic             cf_o
);
  localparam int M = WIDTH - 1;
  logic [WIDTH:0] sum, dif;
  assign sum = {1'b0, a_i} + {1'b0, b_i};
  // The borrow out of the extended difference doubles as the SLTU answer.
  assign dif = {1'b0, a_i} - {1'b0, b_i};
  always_comb begin
    res_o = op_i == OP_AND  ? a_i & b_i :
            op_i == OP_OR   ? a_i | b_i :
            op_i == OP_XOR  ? a_i ^ b_i :
            op_i == OP_XNOR ? ~(a_i ^ b_i) :
            op_i == OP_ADD  ? sum[M:0] :
            op_i == OP_SUB  ? dif[M:0] :
            op_i == OP_SLTU ? WIDTH'(dif[WIDTH]) : '0;
    of_o  = op_i == OP_ADD ? (a_i[M] == b_i[M]) && (sum[M] != a_i[M]) :
            op_i == OP_SUB ? (a_i[M] != b_i[M]) && (dif[M] != a_i[M]) : 1'b0;
    cf_o  = op_i == OP_ADD ? sum[WIDTH] : op_i == OP_SUB ? dif[WIDTH] : 1'b0;
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: parametrised ALU with Start/Busy/Done handshake, registered result and flags,
// and a bit-serial SLL that shifts one position per clock.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] AA,
  input  logic [WIDTH-1:0] BB,
  input  logic [2:0]       ALU_OP,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             OF,
  output logic             CF
);
  localparam logic [WIDTH-1:0] W_LIM   = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, f_q, f_d, res;
  logic [CNT_W-1:0] cnt_q, cnt_d, n;
  logic             zf_q, zf_d, of_q, of_d, cf_q, cf_d, done_q, done_d, ov, cy;
  alu_mc_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i(AA), .b_i(BB), .op_i(ALU_OP), .res_o(res), .of_o(ov), .cf_o(cy)
  );
  // Shifting more than WIDTH places only ever yields zero, so the count saturates.
  assign n = AA >= W_LIM ? CNT_LIM : CNT_W'(AA);
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    zf_d    = zf_q;
    of_d    = of_q;
    cf_d    = cf_q;
    done_d  = 1'b0;
    if (state_q == IDLE && Start && ALU_OP == OP_SLL) begin
      state_d = SHIFT;
      sr_d    = BB;
      cnt_d   = n;
    end else if (state_q == IDLE && Start) begin
      f_d    = res;
      zf_d   = res == '0;
      of_d   = ov;
      cf_d   = cy;
      done_d = 1'b1;
    end else if (state_q == SHIFT && cnt_q != '0) begin
      sr_d  = sr_q << 1;
      cnt_d = cnt_q - 1'b1;
    end else if (state_q == SHIFT) begin
      state_d = IDLE;
      f_d     = sr_q;
      zf_d    = sr_q == '0;
      of_d    = 1'b0;
      cf_d    = 1'b0;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      zf_q    <= 1'b1;
      of_q    <= 1'b0;
      cf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      zf_q    <= zf_d;
      of_q    <= of_d;
      cf_q    <= cf_d;
      done_q  <= done_d;
    end
  end
  assign Busy = state_q == SHIFT;
  assign Done = done_q;
  assign F    = f_q;
  assign ZF   = zf_q;
  assign OF   = of_q;
  assign CF   = cf_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: vector table, hand sequences and a random run against an arithmetic reference model.
module tb_alu_mc;
  logic        CLK = 1'b0;
  logic        RST, Start, Busy, Done, ZF, OF, CF;
  logic [31:0] AA, BB, F;
  logic [2:0]  ALU_OP;
  logic        s8, busy8, done8, zf8, of8, cf8;
  logic [7:0]  a8, b8, f8;
  logic [2:0]  op8;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  alu_mc #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .AA(AA), .BB(BB), .ALU_OP(ALU_OP),
    .Busy(Busy), .Done(Done), .F(F), .ZF(ZF), .OF(OF), .CF(CF)
  );
  alu_mc #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .Start(s8), .AA(a8), .BB(b8), .ALU_OP(op8),
    .Busy(busy8), .Done(done8), .F(f8), .ZF(zf8), .OF(of8), .CF(cf8)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, f;
    logic        zf, of, cf, noise;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {cf, of, zf, f} from plain integer arithmetic.
  function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua = longint'(a), ub = longint'(b);
    longint sa = longint'($signed(a)), sb = longint'($signed(b));
    longint r = 0, s = 0;
    logic [31:0] f;
    logic of = 1'b0, cf = 1'b0;
    case (op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: r = ua ^ ub;
      3'd3: r = ~(ua ^ ub);
      3'd4: begin r = ua + ub; s = sa + sb; cf = r > 64'hFFFF_FFFF; end
      3'd5: begin r = ua - ub; s = sa - sb; cf = ua < ub; end
      3'd6: r = (ua < ub) ? 1 : 0;
      default: r = (ua >= 32) ? 0 : (ub << ua);
    endcase
    if (op == 3'd4 || op == 3'd5) of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    f = r[31:0];
    return {cf, of, f == 0, f};
  endfunction

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic noise, output int lat, output int busy_n);
    @(negedge CLK);
    Start = 1'b1; ALU_OP = op; AA = a; BB = b;
    lat = 0; busy_n = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
      if (!Done) begin
        busy_n += int'(Busy);
        Start = noise;
        if (noise) begin AA = $urandom; BB = $urandom; ALU_OP = 3'($urandom); end
      end
    end while (!Done && lat < 100);
    Start = 1'b0;
  endtask

  task automatic exec(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic noise, input logic [31:0] ef, input logic ezf, input logic eof,
                      input logic ecf, input int elat);
    int lat, busy_n;
    run(op, a, b, noise, lat, busy_n);
    chk({name, " latency"}, lat, elat);
    chk({name, " busy cycles"}, busy_n, elat - 1);
    chk({name, " F"}, F, ef);
    chk({name, " ZF"}, 32'(ZF), 32'(ezf));
    chk({name, " OF"}, 32'(OF), 32'(eof));
    chk({name, " CF"}, 32'(CF), 32'(ecf));
  endtask

  initial begin
    vec_t vecs[$];
    int cnt, lat;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [34:0] m;
    vecs.push_back('{3'd4, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{3'd4, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{3'd5, 32'h3,         32'h5,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{3'd6, 32'h3,         32'h5,         32'h1,         1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'd7, 32'd4,         32'hF,         32'hF0,        1'b0, 1'b0, 1'b0, 1'b1, 6});
    vecs.push_back('{3'd7, 32'd40,        32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 34});
    vecs.push_back('{3'd0, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'd1, 32'hF0F0,      32'h0F00,      32'hFFF0,      1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'd2, 32'hA5,        32'hFF,        32'h5A,        1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'd3, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'd5, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{3'd6, 32'h5,         32'h3,         32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'd7, 32'd0,         32'h1234,      32'h1234,      1'b0, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{3'd7, 32'd31,        32'h1,         32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{3'd7, 32'd32,        32'h1,         32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 34});

    RST = 1'b1; Start = 1'b0; AA = '0; BB = '0; ALU_OP = '0;
    s8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset F", F, 32'h0);
    chk("reset ZF", 32'(ZF), 32'h1);
    chk("reset OF/CF", {30'h0, OF, CF}, 32'h0);
    chk("reset Busy/Done", {30'h0, Busy, Done}, 32'h0);
    chk("reset F8/ZF8", {23'h0, f8, zf8}, 32'h1);
    @(negedge CLK);
    RST = 1'b0;

    foreach (vecs[i])
      exec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].noise,
           vecs[i].f, vecs[i].zf, vecs[i].of, vecs[i].cf, vecs[i].lat);

    repeat (3) @(posedge CLK);
    #1;
    chk("hold F", F, 32'h0);
    chk("hold Done", 32'(Done), 32'h0);

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom);
      a = (op == 3'd7) ? 32'($urandom_range(0, 40)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      m = model(op, a, b);
      exec($sformatf("rand%0d op%0d", i, op), op, a, b, 1'($urandom), m[31:0], m[32], m[33], m[34],
           (op == 3'd7) ? ((a > 32) ? 34 : int'(a) + 2) : 1);
    end

    exec("pre-abort SLTU", 3'd6, 32'h3, 32'h5, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0, 1);
    @(negedge CLK);
    Start = 1'b1; ALU_OP = 3'd7; AA = 32'd40; BB = 32'hFFFF_FFFF;
    @(negedge CLK);
    Start = 1'b0;
    repeat (5) @(negedge CLK);
    chk("abort busy before reset", 32'(Busy), 32'h1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("abort F", F, 32'h0);
    chk("abort ZF", 32'(ZF), 32'h1);
    chk("abort Busy/Done/OF/CF", {28'h0, Busy, Done, OF, CF}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    cnt = 0;
    repeat (40) begin @(posedge CLK); #1; cnt += int'(Done); end
    chk("abort no Done", cnt, 0);

    @(negedge CLK);
    RST = 1'b1; Start = 1'b1; ALU_OP = 3'd4; AA = 32'h1; BB = 32'h1;
    @(negedge CLK);
    RST = 1'b0; Start = 1'b0;
    cnt = 0;
    repeat (4) begin @(posedge CLK); #1; cnt += int'(Done); end
    chk("rst+start no Done", cnt, 0);
    chk("rst+start F", F, 32'h0);

    @(negedge CLK);
    s8 = 1'b1; op8 = 3'd4; a8 = 8'h80; b8 = 8'h80;
    @(posedge CLK); #1;
    s8 = 1'b0;
    chk("w8 add Done", 32'(done8), 32'h1);
    chk("w8 add F", 32'(f8), 32'h0);
    chk("w8 add ZF/OF/CF", {29'h0, zf8, of8, cf8}, 32'h7);
    @(negedge CLK);
    s8 = 1'b1; op8 = 3'd7; a8 = 8'd9; b8 = 8'hFF;
    lat = 0;
    do begin @(posedge CLK); #1; s8 = 1'b0; lat++; end while (!done8 && lat < 100);
    chk("w8 sll9 latency", lat, 10);
    chk("w8 sll9 F/ZF", {23'h0, f8, zf8}, 32'h1);
    @(negedge CLK);
    s8 = 1'b1; op8 = 3'd7; a8 = 8'd3; b8 = 8'h81;
    lat = 0;
    do begin @(posedge CLK); #1; s8 = 1'b0; lat++; end while (!done8 && lat < 100);
    chk("w8 sll3 latency", lat, 5);
    chk("w8 sll3 F", 32'(f8), 32'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
